// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline register with load extraction, result select
// and a retired-instruction counter for the 5-stage RV32I core.
module mem_wb_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_w_i,
  input  logic                 flush_w_i,
  input  logic                 valid_m_i,
  input  logic                 reg_write_m_i,
  input  logic [1:0]           result_src_m_i,
  input  logic [2:0]           funct3_m_i,
  input  logic [4:0]           rd_m_i,
  input  logic [WIDTH-1:0]     alu_result_m_i,
  input  logic [WIDTH-1:0]     read_data_m_i,
  input  logic [WIDTH-1:0]     pc_plus_4_m_i,
  output logic                 valid_w_o,
  output logic                 reg_write_w_o,
  output logic [4:0]           rd_w_o,
  output logic [WIDTH-1:0]     result_w_o,
  output logic [CNT_WIDTH-1:0] retired_count_o
);

  logic                 valid_q;
  logic                 reg_write_q;
  logic [1:0]           src_q;
  logic [2:0]           f3_q;
  logic [4:0]           rd_q;
  logic [WIDTH-1:0]     alu_q;
  logic [WIDTH-1:0]     read_q;
  logic [WIDTH-1:0]     pc4_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Update priority is reset > flush > stall > load. An instruction retires
  // on the edge it leaves W, so a flush still retires what W currently holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      src_q       <= 2'b00;
      f3_q        <= 3'b000;
      rd_q        <= 5'd0;
      alu_q       <= '0;
      read_q      <= '0;
      pc4_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (valid_q && !stall_w_i) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (flush_w_i) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        src_q       <= 2'b00;
        f3_q        <= 3'b000;
        rd_q        <= 5'd0;
        alu_q       <= '0;
        read_q      <= '0;
        pc4_q       <= '0;
      end else if (!stall_w_i) begin
        valid_q     <= valid_m_i;
        reg_write_q <= reg_write_m_i;
        src_q       <= result_src_m_i;
        f3_q        <= funct3_m_i;
        rd_q        <= rd_m_i;
        alu_q       <= alu_result_m_i;
        read_q      <= read_data_m_i;
        pc4_q       <= pc_plus_4_m_i;
      end
    end
  end

  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [WIDTH-1:0] load_data;

  // Halfword selection ignores off[0]; misaligned accesses do not trap here.
  always_comb begin
    load_byte = 8'h00;
    case (alu_q[1:0])
      2'd0:    load_byte = read_q[7:0];
      2'd1:    load_byte = read_q[15:8];
      2'd2:    load_byte = read_q[23:16];
      default: load_byte = read_q[31:24];
    endcase
    load_half = alu_q[1] ? read_q[31:16] : read_q[15:0];
    case (f3_q)
      3'b000:  load_data = {{(WIDTH-8){load_byte[7]}}, load_byte};
      3'b001:  load_data = {{(WIDTH-16){load_half[15]}}, load_half};
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, load_byte};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, load_half};
      default: load_data = read_q;
    endcase
  end

  always_comb begin
    case (src_q)
      2'b01:   result_w_o = load_data;
      2'b10:   result_w_o = pc4_q;
      default: result_w_o = alu_q;
    endcase
  end

  assign valid_w_o       = valid_q;
  assign reg_write_w_o   = reg_write_q & valid_q & (rd_q != 5'd0);
  assign rd_w_o          = rd_q;
  assign retired_count_o = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus randomized bench for mem_wb_stage; a 32-bit and a 4-bit
// counter instance share one stimulus stream and one reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, valid_m, rw_m;
  logic [1:0]  src_m;
  logic [2:0]  f3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_m, raw_m, pc4_m;

  logic        valid_w, rw_w, valid_w4, rw_w4;
  logic [4:0]  rd_w, rd_w4;
  logic [31:0] result_w, result_w4, cnt32;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;

  // reference model of the W contents and retired count
  logic        m_valid, m_rw;
  logic [1:0]  m_src;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_raw, m_pc4;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(32), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall_w_i(stall), .flush_w_i(flush),
    .valid_m_i(valid_m), .reg_write_m_i(rw_m), .result_src_m_i(src_m),
    .funct3_m_i(f3_m), .rd_m_i(rd_m), .alu_result_m_i(alu_m),
    .read_data_m_i(raw_m), .pc_plus_4_m_i(pc4_m),
    .valid_w_o(valid_w), .reg_write_w_o(rw_w), .rd_w_o(rd_w),
    .result_w_o(result_w), .retired_count_o(cnt32)
  );

  mem_wb_stage #(.WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .stall_w_i(stall), .flush_w_i(flush),
    .valid_m_i(valid_m), .reg_write_m_i(rw_m), .result_src_m_i(src_m),
    .funct3_m_i(f3_m), .rd_m_i(rd_m), .alu_result_m_i(alu_m),
    .read_data_m_i(raw_m), .pc_plus_4_m_i(pc4_m),
    .valid_w_o(valid_w4), .reg_write_w_o(rw_w4), .rd_w_o(rd_w4),
    .result_w_o(result_w4), .retired_count_o(cnt4)
  );

  function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [2:0] f3,
                                             input logic [31:0] alu, input logic [31:0] raw,
                                             input logic [31:0] pc4);
    int unsigned off, b, h;
    off = alu % 4;
    b = (raw >> (8 * off)) % 256;
    h = (raw >> (16 * (off / 2))) % 65536;
    if (src == 2'd2) return pc4;
    if (src != 2'd1) return alu;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_rw;
    exp_rw = m_rw && m_valid && (m_rd != 5'd0);
    check("valid", {31'd0, valid_w}, {31'd0, m_valid});
    check("reg_write", {31'd0, rw_w}, {31'd0, exp_rw});
    check("rd", {27'd0, rd_w}, {27'd0, m_rd});
    check("result", result_w, ref_result(m_src, m_f3, m_alu, m_raw, m_pc4));
    check("count32", cnt32, m_cnt);
    check("count4", {28'd0, cnt4}, m_cnt % 16);
    check("result4", result_w4, result_w);
    check("reg_write4", {31'd0, rw_w4}, {31'd0, exp_rw});
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] raw, input logic [31:0] pc4,
                       input logic st, input logic fl);
    valid_m = v; rw_m = rw; src_m = src; f3_m = f3; rd_m = rd;
    alu_m = alu; raw_m = raw; pc4_m = pc4; stall = st; flush = fl;
  endtask

  task automatic tick(input bit do_check);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
      m_alu = 0; m_raw = 0; m_pc4 = 0; m_cnt = 0;
    end else begin
      if (m_valid && !stall) m_cnt++;
      if (flush) begin
        m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
        m_alu = 0; m_raw = 0; m_pc4 = 0;
      end else if (!stall) begin
        m_valid = valid_m; m_rw = rw_m; m_src = src_m; m_f3 = f3_m; m_rd = rd_m;
        m_alu = alu_m; m_raw = raw_m; m_pc4 = pc4_m;
      end
    end
    #1;
    if (do_check) check_all();
  endtask

  initial begin
    int unsigned c0;
    m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
    m_alu = 0; m_raw = 0; m_pc4 = 0; m_cnt = 0;

    // reset then idle
    rst_n = 1'b0;
    drive(0, 0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    tick(1); tick(1);
    check("rst_result", result_w, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick(1);
    check("idle_count", cnt32, 32'd0);

    // load sweep
    drive(1, 1, 2'd1, 3'b000, 5'd5, 32'h100, 32'h81F2_7F80, 32'h0, 0, 0); tick(1);
    check("lb_off0", result_w, 32'hFFFF_FF80);
    check("lb_rw", {31'd0, rw_w}, 32'd1);
    drive(1, 1, 2'd1, 3'b100, 5'd5, 32'h100, 32'h81F2_7F80, 32'h0, 0, 0); tick(1);
    check("lbu_off0", result_w, 32'h0000_0080);
    drive(1, 1, 2'd1, 3'b000, 5'd5, 32'h101, 32'h81F2_7F80, 32'h0, 0, 0); tick(1);
    check("lb_off1", result_w, 32'h0000_007F);
    drive(1, 1, 2'd1, 3'b001, 5'd5, 32'h102, 32'h81F2_7F80, 32'h0, 0, 0); tick(1);
    check("lh_off2", result_w, 32'hFFFF_81F2);
    drive(1, 1, 2'd1, 3'b101, 5'd5, 32'h103, 32'h81F2_7F80, 32'h0, 0, 0); tick(1);
    check("lhu_off3", result_w, 32'h0000_81F2);
    drive(1, 1, 2'd1, 3'b010, 5'd5, 32'h103, 32'h81F2_7F80, 32'h0, 0, 0); tick(1);
    check("lw", result_w, 32'h81F2_7F80);
    drive(1, 1, 2'd1, 3'b111, 5'd5, 32'h101, 32'h81F2_7F80, 32'h0, 0, 0); tick(1);
    check("f3_111_raw", result_w, 32'h81F2_7F80);

    // source select
    drive(1, 1, 2'd0, 3'd0, 5'd9, 32'h1234, 32'hDEAD_BEEF, 32'h104, 0, 0); tick(1);
    check("src00", result_w, 32'h1234);
    drive(1, 1, 2'd2, 3'd0, 5'd9, 32'h1234, 32'hDEAD_BEEF, 32'h104, 0, 0); tick(1);
    check("src10", result_w, 32'h104);
    drive(1, 1, 2'd3, 3'd0, 5'd9, 32'h1234, 32'hDEAD_BEEF, 32'h104, 0, 0); tick(1);
    check("src11", result_w, 32'h1234);
    drive(1, 1, 2'd0, 3'd0, 5'd0, 32'h1234, 32'hDEAD_BEEF, 32'h104, 0, 0); tick(1);
    check("x0_suppress", {31'd0, rw_w}, 32'd0);

    // stall three cycles with an ALU instruction in W
    drive(1, 1, 2'd0, 3'd0, 5'd7, 32'h55, 32'h0, 32'h0, 0, 0); tick(1);
    c0 = m_cnt;
    drive(1, 1, 2'd2, 3'd0, 5'd3, 32'h99, 32'h0, 32'h77, 1, 0);
    repeat (3) begin
      tick(1);
      check("stall_hold", result_w, 32'h55);
      check("stall_count", cnt32, c0);
    end
    stall = 1'b0; tick(1);
    check("stall_release", cnt32, c0 + 1);
    check("stall_next", result_w, 32'h77);

    // flush and stall together
    c0 = m_cnt;
    drive(1, 1, 2'd0, 3'd0, 5'd4, 32'h66, 32'h0, 32'h0, 1, 1); tick(1);
    check("flush_stall_valid", {31'd0, valid_w}, 32'd0);
    check("flush_stall_count", cnt32, c0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      tick(1);
    end
    rst_n = 1'b1;

    // counter wrap on the 4-bit instance
    rst_n = 1'b0;
    drive(0, 0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0); tick(1);
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      drive(1, 1, 2'd0, 3'd0, 5'd1, 32'(i), 32'd0, 32'd0, 0, 0); tick(1);
      if (i == 16) check("wrap_15", {28'd0, cnt4}, 32'd15);
      if (i == 17) check("wrap_0", {28'd0, cnt4}, 32'd0);
    end
    drive(0, 0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0); tick(1);
    check("wrap_1", {28'd0, cnt4}, 32'd1);
    check("wrap_count32", cnt32, 32'd17);

    // reset while stalled with valid data
    drive(1, 1, 2'd0, 3'd0, 5'd8, 32'hABCD, 32'd0, 32'd0, 0, 0); tick(1);
    stall = 1'b1; tick(1);
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1;
    check("midrst_valid", {31'd0, valid_w}, 32'd0);
    check("midrst_rw", {31'd0, rw_w}, 32'd0);
    check("midrst_count", cnt32, 32'd0);
    stall = 1'b0;

    // unknown M inputs with valid low must not enable a write
    drive(0, 1'bx, 2'bxx, 3'bxxx, 5'bxxxxx, 32'hx, 32'hx, 32'hx, 0, 0); tick(0);
    check("x_valid", {31'd0, valid_w}, 32'd0);
    check("x_reg_write", {31'd0, rw_w}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
